// File: rtl/itch_pkg.sv
// ----------------------------------------------------------------------------
// itch_pkg
// Shared definitions for the ITCH message serializer and its peers:
//   - ASCII message-type codes for the supported order messages
//   - message lengths (bytes, type byte included)
//   - big-endian byte offsets of every field inside a message
//   - itch_msg_t, the decoded message bundle
//   - build_frame(), which lays a decoded message out as its wire image
// ----------------------------------------------------------------------------
package itch_pkg;

    localparam logic [7:0] MSG_A = 8'h41;
    localparam logic [7:0] MSG_E = 8'h45;
    localparam logic [7:0] MSG_X = 8'h58;
    localparam logic [7:0] MSG_D = 8'h44;
    localparam logic [7:0] MSG_U = 8'h55;
    localparam logic [7:0] MSG_F = 8'h46;

    localparam int LEN_D = 19;
    localparam int LEN_X = 23;
    localparam int LEN_E = 31;
    localparam int LEN_U = 35;
    localparam int LEN_A = 36;
    localparam int LEN_F = 40;

    // Width of a length value; F is the longest supported message.
    localparam int LEN_W   = $clog2(LEN_F + 1);
    // Wire image of the longest message, byte 0 in the top bits.
    localparam int FRAME_W = LEN_F * 8;

    // Header shared by every message type
    localparam int OFF_TYPE      = 0;
    localparam int OFF_LOCATE    = 1;
    localparam int OFF_TRACKING  = 3;
    localparam int OFF_TIMESTAMP = 5;
    localparam int OFF_ORDER_REF = 11;
    // X and E
    localparam int OFF_X_SHARES  = 19;
    localparam int OFF_E_MATCH   = 23;
    // A and F
    localparam int OFF_A_BUY_SELL = 19;
    localparam int OFF_A_SHARES   = 20;
    localparam int OFF_A_STOCK    = 24;
    localparam int OFF_A_PRICE    = 32;
    localparam int OFF_F_ATTRIB   = 36;
    // U
    localparam int OFF_U_NEW_REF  = 19;
    localparam int OFF_U_SHARES   = 27;
    localparam int OFF_U_PRICE    = 31;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_t;

    typedef struct packed {
        logic [7:0]  msg_type;
        logic [15:0] stock_locate;
        logic [15:0] tracking_no;
        logic [47:0] timestamp;
        logic [63:0] order_ref_no;
        logic [31:0] shares;
        logic [31:0] price;
        logic [7:0]  buy_sell;
        logic [63:0] stock;
        logic [63:0] match_no;
        logic [63:0] new_order_ref_no;
        logic [31:0] attribution;
    } itch_msg_t;

    // Byte n of the message ends up at bits [FRAME_W-1-8n -: 8]; bytes past
    // the end of a shorter message are left zero.
    function automatic logic [FRAME_W-1:0] build_frame(input itch_msg_t m);
        logic [FRAME_W-1:0] f;
        f = '0;
        f[FRAME_W-1-8*OFF_TYPE      -: 8]  = m.msg_type;
        f[FRAME_W-1-8*OFF_LOCATE    -: 16] = m.stock_locate;
        f[FRAME_W-1-8*OFF_TRACKING  -: 16] = m.tracking_no;
        f[FRAME_W-1-8*OFF_TIMESTAMP -: 48] = m.timestamp;
        f[FRAME_W-1-8*OFF_ORDER_REF -: 64] = m.order_ref_no;
        case (m.msg_type)
            MSG_X: begin
                f[FRAME_W-1-8*OFF_X_SHARES -: 32] = m.shares;
            end
            MSG_E: begin
                f[FRAME_W-1-8*OFF_X_SHARES -: 32] = m.shares;
                f[FRAME_W-1-8*OFF_E_MATCH  -: 64] = m.match_no;
            end
            MSG_A, MSG_F: begin
                f[FRAME_W-1-8*OFF_A_BUY_SELL -: 8]  = m.buy_sell;
                f[FRAME_W-1-8*OFF_A_SHARES   -: 32] = m.shares;
                f[FRAME_W-1-8*OFF_A_STOCK    -: 64] = m.stock;
                f[FRAME_W-1-8*OFF_A_PRICE    -: 32] = m.price;
                if (m.msg_type == MSG_F) begin
                    f[FRAME_W-1-8*OFF_F_ATTRIB -: 32] = m.attribution;
                end
            end
            MSG_U: begin
                f[FRAME_W-1-8*OFF_U_NEW_REF -: 64] = m.new_order_ref_no;
                f[FRAME_W-1-8*OFF_U_SHARES  -: 32] = m.shares;
                f[FRAME_W-1-8*OFF_U_PRICE   -: 32] = m.price;
            end
            default: ;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/itch_msg_serializer_if.sv
// ----------------------------------------------------------------------------
// itch_msg_serializer_if
// Bundles the parallel load side and the byte-serial output side of the
// ITCH message serializer.
//   load side  : load, in_ready, msg_type and all decoded field values
//   output side: message, valid, start_msg, end_msg, type_err
// Modports:
//   master - message source (drives load and fields, observes the stream)
//   slave  - the serializer
// ----------------------------------------------------------------------------
interface itch_msg_serializer_if;

    logic        load;
    logic        in_ready;
    logic [7:0]  msg_type;
    logic [15:0] stock_locate;
    logic [15:0] tracking_no;
    logic [47:0] timestamp;
    logic [63:0] order_ref_no;
    logic [31:0] shares;
    logic [31:0] price;
    logic [7:0]  buy_sell;
    logic [63:0] stock;
    logic [63:0] match_no;
    logic [63:0] new_order_ref_no;
    logic [31:0] attribution;

    logic [7:0]  message;
    logic        valid;
    logic        start_msg;
    logic        end_msg;
    logic        type_err;

    modport master (
        output load, msg_type, stock_locate, tracking_no, timestamp,
               order_ref_no, shares, price, buy_sell, stock, match_no,
               new_order_ref_no, attribution,
        input  in_ready, message, valid, start_msg, end_msg, type_err
    );

    modport slave (
        input  load, msg_type, stock_locate, tracking_no, timestamp,
               order_ref_no, shares, price, buy_sell, stock, match_no,
               new_order_ref_no, attribution,
        output in_ready, message, valid, start_msg, end_msg, type_err
    );

endinterface

// File: rtl/itch_len_lut.sv
// ----------------------------------------------------------------------------
// itch_len_lut
// Combinational ITCH message-type decoder: maps an ASCII type byte to its
// total message length and flags whether the type is supported.
// Ports:
//   msg_type  in   8      ASCII message type
//   supported out  1      type is one of A, E, X, D, U, F
//   len       out  LEN_W  message length in bytes (0 when unsupported)
// ----------------------------------------------------------------------------
module itch_len_lut
    import itch_pkg::*;
(
    input  logic [7:0]       msg_type,
    output logic             supported,
    output logic [LEN_W-1:0] len
);

    always_comb begin
        supported = 1'b1;
        len       = '0;
        case (msg_type)
            MSG_D:   len = LEN_W'(LEN_D);
            MSG_X:   len = LEN_W'(LEN_X);
            MSG_E:   len = LEN_W'(LEN_E);
            MSG_U:   len = LEN_W'(LEN_U);
            MSG_A:   len = LEN_W'(LEN_A);
            MSG_F:   len = LEN_W'(LEN_F);
            default: supported = 1'b0;
        endcase
    end

endmodule

// File: rtl/itch_msg_serializer.sv
// ----------------------------------------------------------------------------
// itch_msg_serializer
// Accepts one decoded ITCH order message in parallel and emits it as a
// contiguous big-endian byte stream framed by start_msg / end_msg.
// Ports:
//   clk  in  clock
//   rst  in  asynchronous, active-high reset
//   bus  slave modport of itch_msg_serializer_if
//        load/in_ready handshake plus fields in; message/valid/start_msg/
//        end_msg/type_err out (type_err is a one-cycle reject pulse)
// Parameters:
//   MAX_LEN  longest accepted message in bytes; sizes the byte counter
// Build option:
//   ITCH_SER_BACK2BACK_EN  when defined, in_ready is also high during the
//                          end_msg cycle so messages can follow with no gap
// ----------------------------------------------------------------------------
module itch_msg_serializer
    import itch_pkg::*;
#(
    parameter int MAX_LEN = 40
)
(
    input  logic                 clk,
    input  logic                 rst,
    itch_msg_serializer_if.slave bus
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);

    ser_state_t        state;
    ser_state_t        state_next;
    logic [CNT_W-1:0]  byte_idx;
    logic [CNT_W-1:0]  byte_idx_next;
    logic [CNT_W-1:0]  idx_inc;
    logic [CNT_W-1:0]  len_reg;
    itch_msg_t         shadow;
    itch_msg_t         in_msg;

    logic              lut_supported;
    logic [LEN_W-1:0]  lut_len;
    logic              type_ok;
    logic              in_ready;
    logic              accept;
    logic              reject;
    logic              last;

    logic [FRAME_W-1:0] frame;
    logic [FRAME_W-1:0] frame_sh;

    logic [7:0]        tx_byte;
    logic              tx_valid;
    logic              tx_start;
    logic              tx_end;
    logic              err_pulse;
    logic [7:0]        tx_byte_next;
    logic              tx_valid_next;
    logic              tx_start_next;
    logic              tx_end_next;
    logic              err_pulse_next;

    assign in_msg = '{
        msg_type:         bus.msg_type,
        stock_locate:     bus.stock_locate,
        tracking_no:      bus.tracking_no,
        timestamp:        bus.timestamp,
        order_ref_no:     bus.order_ref_no,
        shares:           bus.shares,
        price:            bus.price,
        buy_sell:         bus.buy_sell,
        stock:            bus.stock,
        match_no:         bus.match_no,
        new_order_ref_no: bus.new_order_ref_no,
        attribution:      bus.attribution
    };

    itch_len_lut u_len_lut (
        .msg_type  (bus.msg_type),
        .supported (lut_supported),
        .len       (lut_len)
    );

    // Rejecting over-long types here keeps byte_idx from ever wrapping.
    assign type_ok = lut_supported && (int'(lut_len) <= MAX_LEN);

    assign last = (state == ST_SEND) && (byte_idx == len_reg - CNT_W'(1));

`ifdef ITCH_SER_BACK2BACK_EN
    assign in_ready = (state == ST_IDLE) || last;
`else
    assign in_ready = (state == ST_IDLE);
`endif

    assign accept  = bus.load && in_ready && type_ok;
    assign reject  = bus.load && in_ready && !type_ok;
    assign idx_inc = byte_idx + CNT_W'(1);

    // Byte idx_inc of the latched message, shifted to the top of the frame.
    assign frame    = build_frame(shadow);
    assign frame_sh = frame << {idx_inc, 3'b000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_next = ST_SEND;
            end
            ST_SEND: begin
                if (last) state_next = accept ? ST_SEND : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Next values of the registered stream outputs. An accept always starts
    // a fresh message with the type byte taken straight from the bus, since
    // the shadow copy is only being written on that same edge.
    always_comb begin
        byte_idx_next  = '0;
        tx_byte_next   = '0;
        tx_valid_next  = 1'b0;
        tx_start_next  = 1'b0;
        tx_end_next    = 1'b0;
        err_pulse_next = reject;
        if (accept) begin
            tx_byte_next  = bus.msg_type;
            tx_valid_next = 1'b1;
            tx_start_next = 1'b1;
        end else if ((state == ST_SEND) && !last) begin
            byte_idx_next = idx_inc;
            tx_byte_next  = frame_sh[FRAME_W-1 -: 8];
            tx_valid_next = 1'b1;
            tx_end_next   = (idx_inc == len_reg - CNT_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx  <= '0;
            len_reg   <= '0;
            shadow    <= '0;
            tx_byte   <= '0;
            tx_valid  <= 1'b0;
            tx_start  <= 1'b0;
            tx_end    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            byte_idx  <= byte_idx_next;
            tx_byte   <= tx_byte_next;
            tx_valid  <= tx_valid_next;
            tx_start  <= tx_start_next;
            tx_end    <= tx_end_next;
            err_pulse <= err_pulse_next;
            if (accept) begin
                shadow  <= in_msg;
                len_reg <= CNT_W'(lut_len);
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.message   = tx_byte;
    assign bus.valid     = tx_valid;
    assign bus.start_msg = tx_start;
    assign bus.end_msg   = tx_end;
    assign bus.type_err  = err_pulse;

endmodule

// File: tb/tb_itch_msg_serializer.sv
// ----------------------------------------------------------------------------
// tb_itch_msg_serializer
// Directed bench for itch_msg_serializer: a table of messages (every
// supported type plus two unsupported ones) with hand-computed lengths, a
// byte-offset reference model and a field decoder for the loopback path,
// followed by hand-written sequences for the multi-cycle corner cases.
// ----------------------------------------------------------------------------
module tb_itch_msg_serializer;
    import itch_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    itch_msg_serializer_if bus ();

    itch_msg_serializer #(.MAX_LEN(40)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        itch_msg_t m;
        int        exp_len;
        bit        exp_err;
    } vec_t;

    vec_t       vecs [8];
    int         n_tests = 0;
    int         n_fail  = 0;

    logic [7:0] cap_b [64];
    int         cap_n, start_cnt, start_pos, end_cnt, end_pos, ready_bad, err_cnt;
    logic       gap_valid, last_ready;

    logic [7:0] d_exp [19];
    logic [7:0] a_exp_19_23 [5];
    logic [7:0] a_exp_32_35 [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic itch_msg_t mk(
        input logic [7:0]  t,   input logic [15:0] loc, input logic [15:0] trk,
        input logic [47:0] ts,  input logic [63:0] rf,  input logic [31:0] sh,
        input logic [31:0] pr,  input logic [7:0]  bs,  input logic [63:0] stk,
        input logic [63:0] mt,  input logic [63:0] nr,  input logic [31:0] at);
        itch_msg_t r;
        r.msg_type = t;   r.stock_locate = loc; r.tracking_no = trk;
        r.timestamp = ts; r.order_ref_no = rf;  r.shares = sh;
        r.price = pr;     r.buy_sell = bs;      r.stock = stk;
        r.match_no = mt;  r.new_order_ref_no = nr; r.attribution = at;
        return r;
    endfunction

    // Byte 'off' (0 = most significant) of an nb-byte big-endian field.
    function automatic logic [7:0] fb(input logic [63:0] f, input int nb, input int off);
        logic [63:0] s;
        s = f >> (8 * (nb - 1 - off));
        return s[7:0];
    endfunction

    function automatic logic [7:0] exp_byte(input itch_msg_t m, input int i);
        if (i == 0)       return m.msg_type;
        else if (i < 3)   return fb(64'(m.stock_locate), 2, i - 1);
        else if (i < 5)   return fb(64'(m.tracking_no), 2, i - 3);
        else if (i < 11)  return fb(64'(m.timestamp), 6, i - 5);
        else if (i < 19)  return fb(m.order_ref_no, 8, i - 11);
        case (m.msg_type)
            MSG_X, MSG_E: begin
                if (i < 23) return fb(64'(m.shares), 4, i - 19);
                else        return fb(m.match_no, 8, i - 23);
            end
            MSG_A, MSG_F: begin
                if (i == 19)     return m.buy_sell;
                else if (i < 24) return fb(64'(m.shares), 4, i - 20);
                else if (i < 32) return fb(m.stock, 8, i - 24);
                else if (i < 36) return fb(64'(m.price), 4, i - 32);
                else             return fb(64'(m.attribution), 4, i - 36);
            end
            MSG_U: begin
                if (i < 27)      return fb(m.new_order_ref_no, 8, i - 19);
                else if (i < 31) return fb(64'(m.shares), 4, i - 27);
                else             return fb(64'(m.price), 4, i - 31);
            end
            default: return 8'h00;
        endcase
    endfunction

    // Reassemble a big-endian field from captured bytes, as the parser would.
    function automatic logic [63:0] be(input int off, input int nb);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < nb; k++) r = (r << 8) | 64'(cap_b[off + k]);
        return r;
    endfunction

    task automatic drive(input itch_msg_t m);
        bus.msg_type = m.msg_type;         bus.stock_locate = m.stock_locate;
        bus.tracking_no = m.tracking_no;   bus.timestamp = m.timestamp;
        bus.order_ref_no = m.order_ref_no; bus.shares = m.shares;
        bus.price = m.price;               bus.buy_sell = m.buy_sell;
        bus.stock = m.stock;               bus.match_no = m.match_no;
        bus.new_order_ref_no = m.new_order_ref_no;
        bus.attribution = m.attribution;
    endtask

    // Present a message for one cycle; returns at the negedge after the
    // sampling edge, where the first byte should be visible.
    task automatic send(input itch_msg_t m, input string tag);
        @(negedge clk);
        drive(m);
        chk($sformatf("%s_ready_before_load", tag), 64'(bus.in_ready), 64'd1);
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    // Record the stream one byte per negedge until end_msg, a drop of valid,
    // byte index stop_at, or the cycle budget. A load with 'inj' fields is
    // pulsed for one cycle after byte inject_at.
    task automatic capture(input int stop_at, input int inject_at, input itch_msg_t inj);
        cap_n = 0; start_cnt = 0; start_pos = -1; end_cnt = 0; end_pos = -1;
        ready_bad = 0; err_cnt = 0; gap_valid = 1'b0; last_ready = 1'b0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            if (!bus.valid) break;
            cap_b[cap_n] = bus.message;
            if (bus.start_msg) begin start_cnt++; start_pos = cap_n; end
            if (bus.end_msg) begin end_cnt++; end_pos = cap_n; last_ready = bus.in_ready; end
            if (bus.type_err) err_cnt++;
            if (!bus.end_msg && bus.in_ready) ready_bad++;
            cap_n++;
            if (cap_n - 1 == stop_at) return;
            if (bus.end_msg) break;
            if (cap_n - 1 == inject_at) begin
                drive(inj);
                bus.load = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
            @(negedge clk);
        end
        bus.load = 1'b0;
        @(negedge clk);
        gap_valid = bus.valid;
        if (bus.type_err) err_cnt++;
    endtask

    task automatic check_stream(input vec_t v, input string tag);
        chk({tag, "_len"},       64'(cap_n),     64'(v.exp_len));
        chk({tag, "_start_cnt"}, 64'(start_cnt), 64'd1);
        chk({tag, "_start_pos"}, 64'(start_pos), 64'd0);
        chk({tag, "_end_cnt"},   64'(end_cnt),   64'd1);
        chk({tag, "_end_pos"},   64'(end_pos),   64'(v.exp_len - 1));
        chk({tag, "_ready_mid"}, 64'(ready_bad), 64'd0);
        chk({tag, "_type_err"},  64'(err_cnt),   64'd0);
        chk({tag, "_gap_valid"}, 64'(gap_valid), 64'd0);
`ifdef ITCH_SER_BACK2BACK_EN
        chk({tag, "_ready_last"}, 64'(last_ready), 64'd1);
`else
        chk({tag, "_ready_last"}, 64'(last_ready), 64'd0);
`endif
        for (int i = 0; i < cap_n && i < v.exp_len; i++)
            chk($sformatf("%s_byte%0d", tag, i), 64'(cap_b[i]), 64'(exp_byte(v.m, i)));
    endtask

    task automatic check_reject(input vec_t v, input string tag);
        int pulses, vld, not_ready;
        send(v.m, tag);
        chk({tag, "_err_now"},   64'(bus.type_err), 64'd1);
        chk({tag, "_valid_now"}, 64'(bus.valid),    64'd0);
        chk({tag, "_ready_now"}, 64'(bus.in_ready), 64'd1);
        pulses = 0; vld = 0; not_ready = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.type_err) pulses++;
            if (bus.valid) vld++;
            if (!bus.in_ready) not_ready++;
            @(negedge clk);
        end
        chk({tag, "_err_pulses"}, 64'(pulses),    64'd1);
        chk({tag, "_valid_seen"}, 64'(vld),       64'd0);
        chk({tag, "_ready_low"},  64'(not_ready), 64'd0);
    endtask

    initial begin
        itch_msg_t inj;
        int        seen;

        vecs[0] = '{mk(MSG_D, 16'h0102, 16'h0304, 48'h0A0B0C0D0E0F, 64'h1122334455667788,
                       32'hDEADBEEF, 32'hCAFEF00D, 8'h53, 64'h5858585858585858,
                       64'hA5A5A5A5A5A5A5A5, 64'h5A5A5A5A5A5A5A5A, 32'h01020304), 19, 1'b0};
        vecs[1] = '{mk(MSG_A, 16'h0005, 16'h0006, 48'h000012345678, 64'h0000000000000A01,
                       32'd100, 32'h0016E360, 8'h42, 64'h4141504C20202020,
                       64'h0, 64'h0, 32'h0), 36, 1'b0};
        vecs[2] = '{mk(MSG_X, 16'h1357, 16'h2468, 48'h112233445566, 64'h0102030405060708,
                       32'h000000C8, 32'h77777777, 8'h99, 64'h0, 64'h0, 64'h0, 32'h0), 23, 1'b0};
        vecs[3] = '{mk(MSG_E, 16'hABCD, 16'h0001, 48'hFFEEDDCCBBAA, 64'h8877665544332211,
                       32'h00001388, 32'h0, 8'h0, 64'h0, 64'h0F1E2D3C4B5A6978,
                       64'h0, 32'h0), 31, 1'b0};
        vecs[4] = '{mk(MSG_U, 16'h0042, 16'h0099, 48'h010203040506, 64'h0000000000001111,
                       32'h000003E8, 32'h00123456, 8'h0, 64'h0, 64'h0,
                       64'h0000000000002222, 32'h0), 35, 1'b0};
        vecs[5] = '{mk(MSG_F, 16'h0077, 16'h0088, 48'h0A0A0B0B0C0C, 64'h00000000DEADBEEF,
                       32'h00000190, 32'h000F4240, 8'h53, 64'h4D53465420202020,
                       64'h0, 64'h0, 32'h4753434F), 40, 1'b0};
        vecs[6] = '{mk(8'h5A, 16'h1111, 16'h2222, 48'h3, 64'h4, 32'h5, 32'h6, 8'h7,
                       64'h8, 64'h9, 64'hA, 32'hB), 0, 1'b1};
        vecs[7] = '{mk(8'h00, 16'h0, 16'h0, 48'h0, 64'h0, 32'h0, 32'h0, 8'h0,
                       64'h0, 64'h0, 64'h0, 32'h0), 0, 1'b1};

        d_exp = '{8'h44, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E,
                  8'h0F, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        a_exp_19_23 = '{8'h42, 8'h00, 8'h00, 8'h00, 8'h64};
        a_exp_32_35 = '{8'h00, 8'h16, 8'hE3, 8'h60};

        rst = 1'b1;
        bus.load = 1'b0;
        drive(vecs[7].m);
        repeat (3) @(negedge clk);
        chk("rst_message",   64'(bus.message),   64'd0);
        chk("rst_valid",     64'(bus.valid),     64'd0);
        chk("rst_start",     64'(bus.start_msg), 64'd0);
        chk("rst_end",       64'(bus.end_msg),   64'd0);
        chk("rst_type_err",  64'(bus.type_err),  64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(bus.in_ready), 64'd1);
        chk("post_rst_valid", 64'(bus.valid),    64'd0);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].exp_err) begin
                check_reject(vecs[i], $sformatf("vec%0d", i));
            end else begin
                send(vecs[i].m, $sformatf("vec%0d", i));
                capture(-1, -1, vecs[i].m);
                check_stream(vecs[i], $sformatf("vec%0d", i));
                if (vecs[i].m.msg_type == MSG_F || vecs[i].m.msg_type == MSG_U) begin
                    chk($sformatf("lb%0d_locate", i), be(1, 2),  64'(vecs[i].m.stock_locate));
                    chk($sformatf("lb%0d_track", i),  be(3, 2),  64'(vecs[i].m.tracking_no));
                    chk($sformatf("lb%0d_ts", i),     be(5, 6),  64'(vecs[i].m.timestamp));
                    chk($sformatf("lb%0d_ref", i),    be(11, 8), vecs[i].m.order_ref_no);
                end
                if (vecs[i].m.msg_type == MSG_F) begin
                    chk("lb_f_buy_sell", be(19, 1), 64'(vecs[i].m.buy_sell));
                    chk("lb_f_shares",   be(20, 4), 64'(vecs[i].m.shares));
                    chk("lb_f_stock",    be(24, 8), vecs[i].m.stock);
                    chk("lb_f_price",    be(32, 4), 64'(vecs[i].m.price));
                    chk("lb_f_attrib",   be(36, 4), 64'(vecs[i].m.attribution));
                end
                if (vecs[i].m.msg_type == MSG_U) begin
                    chk("lb_u_new_ref",  be(19, 8), vecs[i].m.new_order_ref_no);
                    chk("lb_u_shares",   be(27, 4), 64'(vecs[i].m.shares));
                    chk("lb_u_price",    be(31, 4), 64'(vecs[i].m.price));
                end
            end
        end

        // D message against its literal wire image
        send(vecs[0].m, "d_lit");
        capture(-1, -1, vecs[0].m);
        chk("d_lit_len", 64'(cap_n), 64'd19);
        for (int i = 0; i < 19; i++)
            chk($sformatf("d_lit_byte%0d", i), 64'(cap_b[i]), 64'(d_exp[i]));

        // A message: buy_sell/shares and price bytes against literals
        send(vecs[1].m, "a_lit");
        capture(-1, -1, vecs[1].m);
        chk("a_lit_len", 64'(cap_n), 64'd36);
        for (int i = 0; i < 5; i++)
            chk($sformatf("a_lit_byte%0d", 19 + i), 64'(cap_b[19 + i]), 64'(a_exp_19_23[i]));
        for (int i = 0; i < 4; i++)
            chk($sformatf("a_lit_byte%0d", 32 + i), 64'(cap_b[32 + i]), 64'(a_exp_32_35[i]));

        // load with different fields in the middle of an E message is ignored
        inj = vecs[0].m;
        inj.order_ref_no = 64'hFFFF0000FFFF0000;
        inj.stock_locate = 16'hBEEF;
        send(vecs[3].m, "e_inj");
        capture(-1, 5, inj);
        check_stream(vecs[3], "e_inj");

        // reset at byte 10 of an A message, then a clean X message
        drive(vecs[1].m);
        send(vecs[1].m, "a_rst");
        capture(10, -1, vecs[1].m);
        chk("a_rst_bytes_before", 64'(cap_n),   64'd11);
        chk("a_rst_end_before",   64'(end_cnt), 64'd0);
        rst = 1'b1;
        #1;
        chk("a_rst_valid_now",   64'(bus.valid),     64'd0);
        chk("a_rst_start_now",   64'(bus.start_msg), 64'd0);
        chk("a_rst_end_now",     64'(bus.end_msg),   64'd0);
        chk("a_rst_message_now", 64'(bus.message),   64'd0);
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.valid || bus.end_msg) seen++;
        end
        rst = 1'b0;
        seen = seen + 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (bus.valid || bus.end_msg) seen++;
        end
        chk("a_rst_no_tail", 64'(seen), 64'd0);
        chk("a_rst_ready_after", 64'(bus.in_ready), 64'd1);
        send(vecs[2].m, "x_after_rst");
        capture(-1, -1, vecs[2].m);
        check_stream(vecs[2], "x_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
